// File: rtl/pifan_spi_pkg.sv
// Shared definitions for the Pi-to-FPGA SPI0 link (transmit and receive paths).
//   SPI_BYTE_W        : bits per SPI byte
//   SPI_FILL_DEFAULT  : byte sent when the transmitter has nothing queued
//   SPI_MIN_HALF_CLKS : minimum SCK high/low phase, in system clock cycles
//   spi_tx_state_e    : transmit FSM states
package pifan_spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_DEFAULT = 8'hFF;
  localparam int unsigned SPI_MIN_HALF_CLKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_tx_state_e;

endpackage

// File: rtl/spi_slave_tx_if.sv
// Bundle of the SPI pins and the byte handshake of the SPI transmit path.
//   spi_clk, spi_cs   : SCK and active-low CS from the master (asynchronous)
//   tx_data, tx_valid : byte offered for transmission
//   tx_ready          : holding register empty
//   miso, miso_oe     : serial data and pad output enable
//   tx_done, underrun : one-cycle status pulses
//   busy              : synchronised CS asserted
// Modport slave is the transmitter's view; master is the driving side.
interface spi_slave_tx_if;
  import pifan_spi_pkg::*;

  logic                  spi_clk;
  logic                  spi_cs;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  miso;
  logic                  miso_oe;
  logic                  tx_done;
  logic                  underrun;
  logic                  busy;

  modport slave (
    input  spi_clk, spi_cs, tx_data, tx_valid,
    output tx_ready, miso, miso_oe, tx_done, underrun, busy
  );

  modport master (
    output spi_clk, spi_cs, tx_data, tx_valid,
    input  tx_ready, miso, miso_oe, tx_done, underrun, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by an edge detector.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input
//   level    : synchronised level, aligned with the edge pulses
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
// Pin-to-pulse latency is STAGES + 1 cycles. RESET_VAL is the idle level of the input,
// so leaving reset never produces a spurious edge.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode 0 slave transmitter, MSB first, oversampled on the system clock.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : SPI pins plus tx_data/tx_valid/tx_ready handshake and status pulses
// A one-byte holding register feeds an 8-bit shift register. A byte boundary loads the
// held byte, or FILL_BYTE with an underrun pulse when nothing is held.
module spi_slave_tx
  import pifan_spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = SPI_FILL_DEFAULT,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_tx_if.slave bus
);

  logic cs_level, cs_rise, cs_fall;
  logic sck_rise, sck_fall;
  logic unused_sck_level;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.spi_cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.spi_clk),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_tx_state_e         state_q, state_d;
  logic [SPI_BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  reload_q, reload_d;
  logic [SPI_BYTE_W-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;

  logic sck_rise_en, sck_fall_en;
  logic load, done, underrun, accept;

  // SCK activity only matters while the master is selecting us.
  assign sck_rise_en = sck_rise & ~cs_level;
  assign sck_fall_en = sck_fall & ~cs_level;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    reload_d = reload_q;
    load     = 1'b0;
    done     = 1'b0;
    underrun = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        load     = 1'b1;
        bitcnt_d = 3'd0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (sck_rise_en) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            done     = 1'b1;
            reload_d = 1'b1;
          end
        end
        // Master has sampled the last bit; the next byte goes out on this falling edge.
        if (sck_fall_en) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            shreg_d = {shreg_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d  = hold_valid_q ? hold_q : FILL_BYTE;
      underrun = ~hold_valid_q;
    end

    // Deselect wins over everything else; a partial byte is dropped.
    if (cs_rise) begin
      state_d  = IDLE;
      shreg_d  = shreg_q;
      bitcnt_d = 3'd0;
      reload_d = 1'b0;
      load     = 1'b0;
      done     = 1'b0;
      underrun = 1'b0;
    end
  end

  // No bypass: a byte accepted during a load waits for the next boundary.
  assign accept = bus.tx_valid & ~hold_valid_q;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_d       = bus.tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= 3'd0;
      reload_q     <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      reload_q     <= reload_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign bus.tx_ready = ~hold_valid_q;
  assign bus.miso     = (state_q == SHIFT) ? shreg_q[SPI_BYTE_W-1] : 1'b0;
  assign bus.miso_oe  = ~cs_level;
  assign bus.busy     = ~cs_level;
  assign bus.tx_done  = done;
  assign bus.underrun = underrun;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: acts as SPI mode 0 master at clk/8 and byte producer.
module tb_spi_slave_tx;
  import pifan_spi_pkg::*;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Half       = SPI_MIN_HALF_CLKS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_tx_if bus ();

  spi_slave_tx #(
    .FILL_BYTE   (8'hFF),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int und_cnt = 0;

  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.underrun) und_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a byte and hold tx_valid until the accepting edge has passed.
  task automatic offer(input logic [7:0] b);
    int n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_accept", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    wait_clks(2 * Half);
  endtask

  // Clock nbits out; on the last bit of a transfer CS rises together with the SCK fall.
  task automatic xfer(input int nbits, input bit last, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      rx = {rx[6:0], bus.miso};
      bus.spi_clk = 1'b1;
      wait_clks(Half);
      bus.spi_clk = 1'b0;
      if (last && i == nbits - 1) bus.spi_cs = 1'b1;
      wait_clks(Half);
    end
    if (last) wait_clks(Half);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},     32'(bus.miso),     32'd0);
    check({pfx, "_miso_oe"},  32'(bus.miso_oe),  32'd0);
    check({pfx, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check({pfx, "_tx_done"},  32'(bus.tx_done),  32'd0);
    check({pfx, "_underrun"}, 32'(bus.underrun), 32'd0);
    check({pfx, "_busy"},     32'(bus.busy),     32'd0);
  endtask

  logic [7:0] exp_bytes [64];

  initial begin
    logic [7:0] rx;
    logic [7:0] lfsr;
    int d0, u0;

    bus.spi_clk  = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(3);

    // Single byte A5
    offer(8'hA5);
    check("single_ready_low", 32'(bus.tx_ready), 32'd0);
    d0 = done_cnt; u0 = und_cnt;
    cs_low();
    check("single_ready_after_load", 32'(bus.tx_ready), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    check("single_oe", 32'(bus.miso_oe), 32'd1);
    xfer(8, 1'b1, rx);
    check("single_data", 32'(rx), 32'hA5);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("single_underrun", 32'(und_cnt - u0), 32'd0);
    check("single_oe_off", 32'(bus.miso_oe), 32'd0);
    check("single_miso_idle", 32'(bus.miso), 32'd0);

    // Empty holding register
    d0 = done_cnt; u0 = und_cnt;
    cs_low();
    check("empty_underrun_load", 32'(und_cnt - u0), 32'd1);
    xfer(8, 1'b1, rx);
    check("empty_data", 32'(rx), 32'hFF);
    check("empty_underrun", 32'(und_cnt - u0), 32'd1);
    check("empty_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back 3C, C3
    offer(8'h3C);
    d0 = done_cnt; u0 = und_cnt;
    bus.spi_cs = 1'b0;
    wait_clks(SyncStages + 3);
    offer(8'hC3);
    wait_clks(2);
    xfer(8, 1'b0, rx);
    check("b2b_first", 32'(rx), 32'h3C);
    xfer(8, 1'b1, rx);
    check("b2b_second", 32'(rx), 32'hC3);
    check("b2b_done", 32'(done_cnt - d0), 32'd2);
    check("b2b_underrun", 32'(und_cnt - u0), 32'd0);

    // Abort after 4 bits of 5A while accepting 77
    offer(8'h5A);
    d0 = done_cnt; u0 = und_cnt;
    cs_low();
    xfer(4, 1'b0, rx);
    check("abort_nibble", 32'(rx), 32'h5);
    bus.spi_cs = 1'b1;
    offer(8'h77);
    wait_clks(2 * Half);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_oe_off", 32'(bus.miso_oe), 32'd0);
    check("abort_held", 32'(bus.tx_ready), 32'd0);
    cs_low();
    xfer(8, 1'b1, rx);
    check("abort_next_data", 32'(rx), 32'h77);
    check("abort_next_done", 32'(done_cnt - d0), 32'd1);
    check("abort_underrun", 32'(und_cnt - u0), 32'd0);

    // Reset mid-byte: 0x81 shifting, 0x12 held
    offer(8'h81);
    cs_low();
    offer(8'h12);
    xfer(3, 1'b0, rx);
    check("rst_partial", 32'(rx), 32'h4);
    check("rst_pre_held", 32'(bus.tx_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.spi_cs = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    d0 = done_cnt; u0 = und_cnt;
    cs_low();
    xfer(8, 1'b1, rx);
    check("rst_after_data", 32'(rx), 32'hFF);
    check("rst_after_underrun", 32'(und_cnt - u0), 32'd1);
    check("rst_after_done", 32'(done_cnt - d0), 32'd1);

    // 64-byte LFSR stream at clk/8 in one CS
    lfsr = 8'hE1;
    for (int i = 0; i < 64; i++) begin
      exp_bytes[i] = lfsr;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    offer(exp_bytes[0]);
    d0 = done_cnt; u0 = und_cnt;
    cs_low();
    fork
      begin
        for (int i = 1; i < 64; i++) offer(exp_bytes[i]);
      end
      begin
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
          xfer(8, (i == 63), b);
          check($sformatf("lfsr_byte%0d", i), 32'(b), 32'(exp_bytes[i]));
        end
      end
    join
    check("lfsr_done", 32'(done_cnt - d0), 32'd64);
    check("lfsr_underrun", 32'(und_cnt - u0), 32'd0);
    check("lfsr_idle_ready", 32'(bus.tx_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
